// File: rtl/prim_onehot_mon_pkg.sv
// Shared types for the onehot monitor: alert handshake FSM state encoding.
// States are Hamming-distance encoded (min distance 3) so a single flipped
// state bit never lands on another legal state.
package prim_onehot_mon_pkg;

    typedef enum logic [4:0] {
        StIdle = 5'b10010,
        StReq  = 5'b01100,
        StHold = 5'b00111
    } alert_state_e;

endpackage

// File: rtl/prim_onehot_check.sv
// Combinational onehot checker for a single vector.
// Flags: more than one bit set, enable/any-bit disagreement (optional, strict or
// relaxed), and a set bit that is not at the expected address (optional).
module prim_onehot_check #(
    parameter int unsigned AddrWidth   = 5,
    parameter int unsigned OneHotWidth = 2 ** AddrWidth,
    parameter bit          AddrCheck   = 1'b1,
    parameter bit          EnableCheck = 1'b1,
    parameter bit          StrictCheck = 1'b1
) (
    input  logic [OneHotWidth-1:0] oh_i,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic                   en_i,
    output logic                   err_o
);

    logic any_set;
    logic multi_set;
    logic sel_bit;
    logic en_err;
    logic addr_err;

    // Single pass: OR-reduce, detect a second set bit, and pick the addressed bit.
    // An address beyond OneHotWidth selects nothing, so any set bit is a mismatch.
    always_comb begin
        any_set   = 1'b0;
        multi_set = 1'b0;
        sel_bit   = 1'b0;
        for (int unsigned i = 0; i < OneHotWidth; i++) begin
            multi_set = multi_set | (any_set & oh_i[i]);
            any_set   = any_set | oh_i[i];
            if (AddrWidth'(i) == addr_i) begin
                sel_bit = oh_i[i];
            end
        end
    end

    // Relaxed mode only objects to bits set while disabled.
    assign en_err   = EnableCheck ? (StrictCheck ? (en_i ^ any_set) : (~en_i & any_set)) : 1'b0;
    assign addr_err = AddrCheck ? (any_set & ~sel_bit) : 1'b0;
    assign err_o    = multi_set | en_err | addr_err;

endmodule

// File: rtl/prim_onehot_mon.sv
// Multi-channel onehot monitor with sticky per-channel errors, an alert
// request/acknowledge handshake and an optional saturating error-event counter.
// Define PRIM_ONEHOT_MON_ERR_CNT_EN to build the counter; otherwise err_cnt_o is 0.
module prim_onehot_mon
    import prim_onehot_mon_pkg::*;
#(
    parameter int unsigned NumChannels = 2,
    parameter int unsigned AddrWidth   = 5,
    parameter int unsigned OneHotWidth = 2 ** AddrWidth,
    parameter bit          StrictCheck = 1'b1,
    parameter int unsigned CntWidth    = 8
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [NumChannels-1:0][OneHotWidth-1:0] oh_i,
    input  logic [NumChannels-1:0][AddrWidth-1:0]   addr_i,
    input  logic [NumChannels-1:0]                  en_i,
    input  logic                                    clr_i,
    input  logic                                    alert_ack_i,
    output logic [NumChannels-1:0]                  err_ch_o,
    output logic                                    err_o,
    output logic                                    alert_req_o,
    output logic [CntWidth-1:0]                     err_cnt_o
);

    logic [NumChannels-1:0] chk;
    logic [NumChannels-1:0] err_ch_d, err_ch_q;
    logic                   any_chk;
    logic                   clr_eff;
    alert_state_e           state_q;
    logic                   alert_req_q;

    for (genvar c = 0; c < NumChannels; c++) begin : g_check
        prim_onehot_check #(
            .AddrWidth   (AddrWidth),
            .OneHotWidth (OneHotWidth),
            .AddrCheck   (1'b1),
            .EnableCheck (1'b1),
            .StrictCheck (StrictCheck)
        ) u_check (
            .oh_i   (oh_i[c]),
            .addr_i (addr_i[c]),
            .en_i   (en_i[c]),
            .err_o  (chk[c])
        );
    end

    assign any_chk = |chk;
    // Clearing mid-handshake would lose the cause of the pending alert.
    assign clr_eff = clr_i & (state_q != StReq);

    // Sticky errors: clear first, then OR in this cycle's flags so a new error wins.
    always_comb begin
        err_ch_d = clr_eff ? '0 : err_ch_q;
        err_ch_d = err_ch_d | chk;
    end

    // Sticky per-channel error register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_ch_q <= '0;
        end else begin
            err_ch_q <= err_ch_d;
        end
    end

    // Alert handshake FSM; alert_req is registered alongside the state.
    // IDLE always holds err_ch=0, so any flag there is a fresh error. Leaving HOLD
    // needs a clear, which wipes err_ch, so any flag then also counts as fresh.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            alert_req_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (any_chk) begin
                        state_q     <= StReq;
                        alert_req_q <= 1'b1;
                    end
                end
                StReq: begin
                    if (alert_ack_i) begin
                        state_q     <= StHold;
                        alert_req_q <= 1'b0;
                    end
                end
                StHold: begin
                    if (clr_i) begin
                        if (any_chk) begin
                            state_q     <= StReq;
                            alert_req_q <= 1'b1;
                        end else begin
                            state_q     <= StIdle;
                            alert_req_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    // A corrupted state is itself alert-worthy.
                    state_q     <= StReq;
                    alert_req_q <= 1'b1;
                end
            endcase
        end
    end

    assign err_ch_o    = err_ch_q;
    assign err_o       = |err_ch_q;
    assign alert_req_o = alert_req_q;

`ifdef PRIM_ONEHOT_MON_ERR_CNT_EN
    logic [CntWidth-1:0] cnt_base;
    logic [CntWidth-1:0] cnt_q;

    // A clear and a same-cycle error leave the counter at 1.
    always_comb begin
        cnt_base = clr_eff ? '0 : cnt_q;
    end

    // One increment per erroring cycle regardless of channel count; saturates.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (any_chk && (cnt_base != '1)) begin
            cnt_q <= cnt_base + CntWidth'(1);
        end else begin
            cnt_q <= cnt_base;
        end
    end

    assign err_cnt_o = cnt_q;
`else
    assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_prim_onehot_mon.sv
// Bench for prim_onehot_mon: a strict and a relaxed instance share stimulus and
// are compared every cycle against a behavioural model, plus directed checks.
module tb_prim_onehot_mon;

    localparam int NC = 2;
    localparam int AW = 3;
    localparam int OW = 8;
    localparam int CW = 2;
`ifdef PRIM_ONEHOT_MON_ERR_CNT_EN
    localparam bit CntOn = 1'b1;
`else
    localparam bit CntOn = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_ni;
    logic [NC-1:0][OW-1:0]  oh;
    logic [NC-1:0][AW-1:0]  addr;
    logic [NC-1:0]          en;
    logic                   clr;
    logic                   ack;

    logic [NC-1:0] err_ch_s, err_ch_n;
    logic          err_s, err_n;
    logic          alert_s, alert_n;
    logic [CW-1:0] cnt_s, cnt_n;

    int total = 0;
    int bad   = 0;

    // Model state per instance: index 0 strict, 1 relaxed. st: 0 idle, 1 req, 2 hold.
    logic [NC-1:0] m_err [2];
    int            m_cnt [2];
    int            m_st  [2];

    always #5 clk = ~clk;

    prim_onehot_mon #(
        .NumChannels (NC),
        .AddrWidth   (AW),
        .OneHotWidth (OW),
        .StrictCheck (1'b1),
        .CntWidth    (CW)
    ) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .oh_i        (oh),
        .addr_i      (addr),
        .en_i        (en),
        .clr_i       (clr),
        .alert_ack_i (ack),
        .err_ch_o    (err_ch_s),
        .err_o       (err_s),
        .alert_req_o (alert_s),
        .err_cnt_o   (cnt_s)
    );

    prim_onehot_mon #(
        .NumChannels (NC),
        .AddrWidth   (AW),
        .OneHotWidth (OW),
        .StrictCheck (1'b0),
        .CntWidth    (CW)
    ) u_dut_ns (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .oh_i        (oh),
        .addr_i      (addr),
        .en_i        (en),
        .clr_i       (clr),
        .alert_ack_i (ack),
        .err_ch_o    (err_ch_n),
        .err_o       (err_n),
        .alert_req_o (alert_n),
        .err_cnt_o   (cnt_n)
    );

    function automatic bit ref_chk(logic [OW-1:0] v, logic [AW-1:0] a, bit e, bit strict);
        int n;
        bit r;
        n = $countones(v);
        r = 1'b0;
        if (n > 1) r = 1'b1;
        if (strict && (e != (n > 0))) r = 1'b1;
        if (!strict && !e && (n > 0)) r = 1'b1;
        if ((n > 0) && !v[a]) r = 1'b1;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_cnt(int s);
        return CntOn ? m_cnt[s] : 0;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_err[s] = '0;
            m_cnt[s] = 0;
            m_st[s]  = 0;
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        logic [NC-1:0] cv;
        logic [NC-1:0] base;
        logic [NC-1:0] nxt;
        bit            clr_eff;
        bit            sets;
        int            c;
        for (int s = 0; s < 2; s++) begin
            for (int ch = 0; ch < NC; ch++) cv[ch] = ref_chk(oh[ch], addr[ch], en[ch], s == 0);
            clr_eff = clr && (m_st[s] != 1);
            base    = clr_eff ? '0 : m_err[s];
            nxt     = base | cv;
            sets    = ((nxt & ~base) != '0);
            c       = clr_eff ? 0 : m_cnt[s];
            if (cv != '0) c = (c + 1 > 3) ? 3 : c + 1;
            m_err[s] = nxt;
            m_cnt[s] = c;
            case (m_st[s])
                0: if (sets) m_st[s] = 1;
                1: if (ack) m_st[s] = 2;
                default: if (clr) m_st[s] = sets ? 1 : 0;
            endcase
        end
    endtask

    task automatic compare_all();
        check("strict err_ch", 32'(err_ch_s), 32'(m_err[0]));
        check("strict err_o", 32'(err_s), 32'(m_err[0] != '0));
        check("strict alert_req", 32'(alert_s), 32'(m_st[0] == 1));
        check("strict err_cnt", 32'(cnt_s), exp_cnt(0));
        check("relaxed err_ch", 32'(err_ch_n), 32'(m_err[1]));
        check("relaxed err_o", 32'(err_n), 32'(m_err[1] != '0));
        check("relaxed alert_req", 32'(alert_n), 32'(m_st[1] == 1));
        check("relaxed err_cnt", 32'(cnt_n), exp_cnt(1));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        oh   = '0;
        addr = '0;
        en   = '0;
        clr  = 1'b0;
        ack  = 1'b0;
    endtask

    task automatic reset_pulse();
        rst_ni = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check("reset err_ch", 32'(err_ch_s), 32'h0);
        check("reset alert", 32'(alert_s), 32'h0);
        rst_ni = 1'b1;

        // Two bits set on channel 0.
        oh[0] = 8'h06;
        en[0] = 1'b1;
        cycle();
        check("multi err_ch", 32'(err_ch_s), 32'h1);
        check("multi alert", 32'(alert_s), 32'h1);
        check("multi cnt", 32'(cnt_s), CntOn ? 32'h1 : 32'h0);

        // Address mismatch on channel 1.
        idle_inputs();
        oh[1]   = 8'h04;
        addr[1] = 3'd3;
        en[1]   = 1'b1;
        cycle();
        check("addr err_ch1", 32'(err_ch_s[1]), 32'h1);
        check("addr relaxed err_ch1", 32'(err_ch_n[1]), 32'h1);

        // Clear during REQ is ignored.
        idle_inputs();
        clr = 1'b1;
        cycle();
        check("clr in req err_ch", 32'(err_ch_s), 32'h3);
        check("clr in req alert", 32'(alert_s), 32'h1);
        check("clr in req cnt", 32'(cnt_s), CntOn ? 32'h2 : 32'h0);

        // Ack then clear from HOLD.
        idle_inputs();
        ack = 1'b1;
        cycle();
        check("ack alert drop", 32'(alert_s), 32'h0);
        idle_inputs();
        clr = 1'b1;
        cycle();
        check("hold clr err_ch", 32'(err_ch_s), 32'h0);
        check("hold clr cnt", 32'(cnt_s), 32'h0);
        idle_inputs();
        cycle();
        check("idle alert", 32'(alert_s), 32'h0);

        // Saturation: five erroring cycles on both channels.
        oh = {8'h06, 8'h06};
        en = 2'b11;
        repeat (5) cycle();
        check("sat cnt", 32'(cnt_s), CntOn ? 32'h3 : 32'h0);
        check("sat err_ch", 32'(err_ch_s), 32'h3);

        // New error together with clear in HOLD.
        idle_inputs();
        ack = 1'b1;
        cycle();
        idle_inputs();
        cycle();
        check("hold alert", 32'(alert_s), 32'h0);
        clr   = 1'b1;
        oh[0] = 8'h06;
        en[0] = 1'b1;
        cycle();
        check("clr+err cnt", 32'(cnt_s), CntOn ? 32'h1 : 32'h0);
        check("clr+err alert", 32'(alert_s), 32'h1);
        check("clr+err err_ch", 32'(err_ch_s), 32'h1);

        // Reset while the alert is raised drops everything at once.
        rst_ni = 1'b0;
        #1;
        model_reset();
        check("async rst alert", 32'(alert_s), 32'h0);
        check("async rst err_ch", 32'(err_ch_s), 32'h0);
        check("async rst err_o", 32'(err_s), 32'h0);
        check("async rst cnt", 32'(cnt_s), 32'h0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        // Enabled with no bit set: error only in strict mode.
        idle_inputs();
        en = 2'b11;
        cycle();
        check("relaxed zero err_ch", 32'(err_ch_n), 32'h0);
        check("relaxed zero alert", 32'(alert_n), 32'h0);
        check("strict zero err_ch", 32'(err_ch_s), 32'h3);

        idle_inputs();
        reset_pulse();

        // Randomised traffic.
        for (int it = 0; it < 3000; it++) begin
            for (int ch = 0; ch < NC; ch++) begin
                int mode;
                mode     = $urandom_range(0, 7);
                addr[ch] = AW'($urandom_range(0, OW - 1));
                if (mode < 3) begin
                    oh[ch] = '0;
                end else if (mode < 7) begin
                    oh[ch] = '0;
                    if ($urandom_range(0, 3) == 0) oh[ch][$urandom_range(0, OW - 1)] = 1'b1;
                    else oh[ch][addr[ch]] = 1'b1;
                end else begin
                    oh[ch] = OW'($urandom);
                end
                en[ch] = (oh[ch] != '0);
                if ($urandom_range(0, 7) == 0) en[ch] = ~en[ch];
            end
            if ($urandom_range(0, 3) == 0) begin
                oh = '0;
                en = '0;
            end
            clr = ($urandom_range(0, 3) == 0);
            ack = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 399) == 0) reset_pulse();
            else cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
